// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path: FSM encodings, frame geometry
// and the parity helper used when SERIAL_UART_TX_PARITY_EN is defined.
package serial_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int SERIAL_DATA_BITS     = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    function automatic logic even_parity(input logic [SERIAL_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and a separate occupancy counter.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == LW'(DEPTH));
    assign empty     = (count_r == {LW{1'b0}});
    assign level     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/serial_uart_tx.sv
// Buffered asynchronous serial transmitter (8N1, or 8E1 when
// SERIAL_UART_TX_PARITY_EN is defined) fed by the core's serial write port.
module serial_uart_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          wren_in,
    output logic                          ready_out,
    output logic                          tx_out,
    output logic                          busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   level_out,
    output logic                          overflow_out
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(SERIAL_DATA_BITS - 1);

    state_t                      state_r, state_nxt_s;
    logic [BAUD_W-1:0]           baud_r, baud_nxt_s;
    logic [2:0]                  bit_r, bit_nxt_s;
    logic [SERIAL_DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic [SERIAL_DATA_BITS-1:0] head_s;
    logic                        tx_r, tx_nxt_s;
    logic                        overflow_r;
    logic                        pop_s, full_s, empty_s, baud_end_s;
`ifdef SERIAL_UART_TX_PARITY_EN
    logic                        parity_r, parity_nxt_s;
`endif

    sync_fifo #(
        .WIDTH (SERIAL_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (wren_in),
        .pop     (pop_s),
        .wr_data (data_in),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level_out)
    );

    assign ready_out    = !full_s;
    assign busy_out     = (state_r != ST_IDLE) || !empty_s;
    assign tx_out       = tx_r;
    assign overflow_out = overflow_r;
    assign baud_end_s   = (baud_r == BAUD_LAST);

    // Next-state, baud, bit index, shift register and FIFO pop decision.
    always_comb begin
        state_nxt_s = state_r;
        baud_nxt_s  = baud_r + 1'b1;
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        pop_s       = 1'b0;
`ifdef SERIAL_UART_TX_PARITY_EN
        parity_nxt_s = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                baud_nxt_s = {BAUD_W{1'b0}};
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = head_s;
                    state_nxt_s = ST_START;
`ifdef SERIAL_UART_TX_PARITY_EN
                    parity_nxt_s = even_parity(head_s);
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_nxt_s  = {BAUD_W{1'b0}};
                    bit_nxt_s   = 3'd0;
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_nxt_s = {BAUD_W{1'b0}};
                    if (bit_r == BIT_LAST) begin
                        bit_nxt_s = 3'd0;
`ifdef SERIAL_UART_TX_PARITY_EN
                        state_nxt_s = ST_PARITY;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        bit_nxt_s   = bit_r + 3'd1;
                        shift_nxt_s = {1'b0, shift_r[SERIAL_DATA_BITS-1:1]};
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef SERIAL_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end_s) begin
                    baud_nxt_s  = {BAUD_W{1'b0}};
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_nxt_s = {BAUD_W{1'b0}};
                    // Chain straight into the next frame so the line never idles between bytes.
                    if (!empty_s) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = head_s;
                        state_nxt_s = ST_START;
`ifdef SERIAL_UART_TX_PARITY_EN
                        parity_nxt_s = even_parity(head_s);
`endif
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                baud_nxt_s  = {BAUD_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, so tx_out changes on the same edge as the state.
    always_comb begin
        tx_nxt_s = 1'b1;
        case (state_nxt_s)
            ST_START: tx_nxt_s = 1'b0;
            ST_DATA:  tx_nxt_s = shift_nxt_s[0];
`ifdef SERIAL_UART_TX_PARITY_EN
            ST_PARITY: tx_nxt_s = parity_nxt_s;
`endif
            ST_IDLE:  tx_nxt_s = 1'b1;
            ST_STOP:  tx_nxt_s = 1'b1;
            default:  tx_nxt_s = 1'b1;
        endcase
    end

    // Transmitter state registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            baud_r     <= {BAUD_W{1'b0}};
            bit_r      <= 3'd0;
            shift_r    <= {SERIAL_DATA_BITS{1'b0}};
            tx_r       <= 1'b1;
            overflow_r <= 1'b0;
`ifdef SERIAL_UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            baud_r     <= baud_nxt_s;
            bit_r      <= bit_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_r       <= tx_nxt_s;
            overflow_r <= wren_in && full_s;
`ifdef SERIAL_UART_TX_PARITY_EN
            parity_r   <= parity_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_serial_uart_tx.sv
// Directed bench for serial_uart_tx with a byte scoreboard and a line decoder.
// Parity checks are enabled when SERIAL_UART_TX_PARITY_EN is defined.
module tb_serial_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef SERIAL_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       wren_in = 1'b0;
    logic       ready_out, tx_out, busy_out, overflow_out;
    logic [4:0] level_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] sb_q[$];
    int         start_q[$];

    bit          mon_in_frame = 1'b0;
    int          mon_pos = 0;
    logic [10:0] mon_bits = 11'd0;
    logic [7:0]  mon_byte = 8'd0;

    serial_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .wren_in      (wren_in),
        .ready_out    (ready_out),
        .tx_out       (tx_out),
        .busy_out     (busy_out),
        .level_out    (level_out),
        .overflow_out (overflow_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef SERIAL_UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        data_in = b;
        wren_in = 1'b1;
        sb_q.push_back(b);
        tick();
        wren_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy_out === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy_out), 32'd0);
        chk({tag, "_tx"}, 32'(tx_out), 32'd1);
    endtask

    // Line decoder: every frame cycle is compared against the byte at the scoreboard head.
    initial begin
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                mon_in_frame = 1'b0;
            end else if (!mon_in_frame) begin
                if (tx_out !== 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("idle_line", 32'(tx_out), 32'd1);
                    end else begin
                        mon_byte = sb_q.pop_front();
                        mon_bits = frame_bits(mon_byte);
                        start_q.push_back(cyc);
                        chk("start_bit", 32'(tx_out), 32'(mon_bits[0]));
                        mon_in_frame = 1'b1;
                        mon_pos = 1;
                    end
                end
            end else begin
                chk($sformatf("frame_bit_%02h_c%0d", mon_byte, mon_pos), 32'(tx_out),
                    32'(mon_bits[mon_pos / CPB]));
                mon_pos++;
                if (mon_pos == FRAME) mon_in_frame = 1'b0;
            end
        end
    end

    initial begin
        // 1: reset held low for three edges
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_tx", 32'(tx_out), 32'd1);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_level", 32'(level_out), 32'd0);
        chk("rst_overflow", 32'(overflow_out), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_idle_tx", 32'(tx_out), 32'd1);

        // 2: single byte, latency and busy window
        push_byte(8'h55);
        chk("push_level", 32'(level_out), 32'd1);
        chk("push_tx_still_idle", 32'(tx_out), 32'd1);
        chk("push_busy", 32'(busy_out), 32'd1);
        tick();
        chk("latency_start", 32'(tx_out), 32'd0);
        chk("latency_level", 32'(level_out), 32'd0);
        for (int i = 0; i < FRAME; i++) begin
            chk($sformatf("busy_frame_c%0d", i), 32'(busy_out), 32'd1);
            tick();
        end
        chk("busy_after_frame", 32'(busy_out), 32'd0);
        chk("tx_after_frame", 32'(tx_out), 32'd1);

        // 3: fill the FIFO behind a stalled line, then overflow
        push_byte(8'hC3);
        tick();
        chk("stall_level", 32'(level_out), 32'd0);
        for (int i = 0; i < 17; i++) begin
            data_in = 8'(16 + i);
            wren_in = 1'b1;
            if (i == 16) begin
                chk("full_ready", 32'(ready_out), 32'd0);
            end else begin
                chk($sformatf("fill_ready_%0d", i), 32'(ready_out), 32'd1);
                sb_q.push_back(8'(16 + i));
            end
            tick();
            if (i < 16) begin
                chk($sformatf("fill_level_%0d", i), 32'(level_out), 32'(i + 1));
                chk($sformatf("fill_no_ovf_%0d", i), 32'(overflow_out), 32'd0);
            end else begin
                chk("overflow_pulse", 32'(overflow_out), 32'd1);
                chk("overflow_level", 32'(level_out), 32'd16);
            end
        end
        wren_in = 1'b0;
        tick();
        chk("overflow_one_cycle", 32'(overflow_out), 32'd0);
        chk("peak_level_held", 32'(level_out), 32'd16);
        wait_idle(17 * FRAME + 50, "drain_fill");
        chk("drain_scoreboard", 32'(sb_q.size()), 32'd0);
        chk("drain_level", 32'(level_out), 32'd0);

        // 4: back-to-back frames without an idle gap
        start_q.delete();
        push_byte(8'h41);
        push_byte(8'h42);
        wait_idle(3 * FRAME, "drain_b2b");
        chk("b2b_frames", 32'(start_q.size()), 32'd2);
        if (start_q.size() == 2) chk("b2b_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));

        // 5: reset during data bit 3 aborts the frame
        push_byte(8'hA3);
        tick();
        repeat (17) tick();
        chk("abort_pre_bit3", 32'(tx_out), 32'd0);
        reset = 1'b0;
        tick();
        chk("abort_tx", 32'(tx_out), 32'd1);
        chk("abort_level", 32'(level_out), 32'd0);
        chk("abort_busy", 32'(busy_out), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            chk($sformatf("post_abort_line_%0d", i), 32'(tx_out), 32'd1);
        end
        chk("post_abort_busy", 32'(busy_out), 32'd0);
        chk("post_abort_ready", 32'(ready_out), 32'd1);

`ifdef SERIAL_UART_TX_PARITY_EN
        // 6: parity bit value and 11-bit frame length
        push_byte(8'h07);
        tick();
        repeat (38) tick();
        chk("parity_07", 32'(tx_out), 32'd1);
        wait_idle(2 * FRAME, "drain_p07");
        push_byte(8'h03);
        tick();
        repeat (38) tick();
        chk("parity_03", 32'(tx_out), 32'd0);
        wait_idle(2 * FRAME, "drain_p03");
        start_q.delete();
        push_byte(8'h07);
        push_byte(8'h03);
        wait_idle(3 * FRAME, "drain_parity_b2b");
        chk("parity_frames", 32'(start_q.size()), 32'd2);
        if (start_q.size() == 2) chk("parity_frame_len", 32'(start_q[1] - start_q[0]), 32'(11 * CPB));
`endif

        chk("final_scoreboard", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
